// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings for the pipeline hazard controller
package hazard_pkg;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/md_stall_fsm.sv
// rtl/md_stall_fsm.sv - holds the pipe while a multi-cycle mul/div occupies E
module md_stall_fsm
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mul_e,
    input  logic div_e,
    input  logic flush,
    output logic md_start,
    output logic md_stall,
    output logic md_busy
);

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    md_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        md_start   = 1'b0;
        md_stall   = 1'b0;
        if (flush) begin
            // an excepting instruction in M aborts whatever the unit was doing
            state_next = MD_IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (mul_e || div_e) begin
                        md_start = 1'b1;
                        md_stall = 1'b1;
                        if (div_e) begin
                            cnt_next   = DIV_CNT;
                            state_next = (DIV_LAT > 1) ? MD_BUSY : MD_DONE;
                        end else begin
                            cnt_next   = MUL_CNT;
                            state_next = (MUL_LAT > 1) ? MD_BUSY : MD_DONE;
                        end
                    end
                end
                MD_BUSY: begin
                    md_stall = 1'b1;
                    cnt_next = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state_next = MD_DONE;
                    end
                end
                // the op in E still shows mul_e/div_e here, so it is ignored
                MD_DONE: state_next = MD_IDLE;
                default: state_next = MD_IDLE;
            endcase
        end
    end

    assign md_busy = (state != MD_IDLE);

endmodule

// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - forwarding, load/branch interlock and mul/div stall control
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteE,
    input  logic              regwriteM,
    input  logic              regwriteW,
    input  logic              memtoregE,
    input  logic              memtoregM,
    input  logic              branchD,
    input  logic              mulE,
    input  logic              divE,
    input  logic              flush_excM,
    output logic              forwardaD,
    output logic              forwardbD,
    output logic [1:0]        forwardaE,
    output logic [1:0]        forwardbE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              md_start,
    output logic              md_busy
);

    localparam logic [REG_AW-1:0] R0 = '0;

    logic md_start_raw, md_stall, md_busy_raw;
    logic lu_stall, br_stall, ld_stall;
    logic [1:0] fwd_a, fwd_b;

    md_stall_fsm #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_md (
        .clk      (clk),
        .rst_n    (rst_n),
        .mul_e    (mulE),
        .div_e    (divE),
        .flush    (flush_excM),
        .md_start (md_start_raw),
        .md_stall (md_stall),
        .md_busy  (md_busy_raw)
    );

    always_comb begin
        fwd_a = FWD_RF;
        if (rsE != R0 && rsE == writeregM && regwriteM)      fwd_a = FWD_M;
        else if (rsE != R0 && rsE == writeregW && regwriteW) fwd_a = FWD_W;
        fwd_b = FWD_RF;
        if (rtE != R0 && rtE == writeregM && regwriteM)      fwd_b = FWD_M;
        else if (rtE != R0 && rtE == writeregW && regwriteW) fwd_b = FWD_W;
    end

    assign lu_stall = memtoregE && (rtE != R0) && (rtE == rsD || rtE == rtD);
    assign br_stall = branchD &&
        ((regwriteE && writeregE != R0 && (writeregE == rsD || writeregE == rtD)) ||
         (memtoregM && writeregM != R0 && (writeregM == rsD || writeregM == rtD)));
    assign ld_stall = lu_stall || br_stall;

    // every output is forced low while reset is held, combinational ones included
    always_comb begin
        forwardaD = rst_n && (rsD != R0) && (rsD == writeregM) && regwriteM;
        forwardbD = rst_n && (rtD != R0) && (rtD == writeregM) && regwriteM;
        forwardaE = rst_n ? fwd_a : FWD_RF;
        forwardbE = rst_n ? fwd_b : FWD_RF;
        stallF    = rst_n && !flush_excM && (md_stall || ld_stall);
        stallD    = rst_n && !flush_excM && (md_stall || ld_stall);
        stallE    = rst_n && !flush_excM && md_stall;
        flushD    = rst_n && flush_excM;
        // while mul/div holds E the load interlock must not bubble the E op away
        flushE    = rst_n && (flush_excM || (!md_stall && ld_stall));
        flushM    = rst_n && (flush_excM || md_stall);
        md_start  = rst_n && md_start_raw;
        md_busy   = rst_n && md_busy_raw;
    end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb/tb_hazard_unit_mc.sv - directed self-checking bench for hazard_unit_mc
module tb_hazard_unit_mc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic       branchD, mulE, divE, flush_excM;
    logic       forwardaD, forwardbD;
    logic [1:0] forwardaE, forwardbE;
    logic       stallF, stallD, stallE, flushD, flushE, flushM, md_start, md_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_unit_mc #(
        .REG_AW  (5),
        .MUL_LAT (1),
        .DIV_LAT (4),
        .CNT_W   (6)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rsD        (rsD),
        .rtD        (rtD),
        .rsE        (rsE),
        .rtE        (rtE),
        .writeregE  (writeregE),
        .writeregM  (writeregM),
        .writeregW  (writeregW),
        .regwriteE  (regwriteE),
        .regwriteM  (regwriteM),
        .regwriteW  (regwriteW),
        .memtoregE  (memtoregE),
        .memtoregM  (memtoregM),
        .branchD    (branchD),
        .mulE       (mulE),
        .divE       (divE),
        .flush_excM (flush_excM),
        .forwardaD  (forwardaD),
        .forwardbD  (forwardbD),
        .forwardaE  (forwardaE),
        .forwardbE  (forwardbE),
        .stallF     (stallF),
        .stallD     (stallD),
        .stallE     (stallE),
        .flushD     (flushD),
        .flushE     (flushE),
        .flushM     (flushM),
        .md_start   (md_start),
        .md_busy    (md_busy)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {stallF, stallD, stallE, flushD, flushE, flushM, md_start, md_busy}
    function automatic logic [7:0] ctl();
        return {stallF, stallD, stallE, flushD, flushE, flushM, md_start, md_busy};
    endfunction

    task automatic clear_inputs();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0;
        writeregE = 0; writeregM = 0; writeregW = 0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0;
        memtoregE = 0; memtoregM = 0; branchD = 0;
        mulE = 0; divE = 0; flush_excM = 0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        rsE = 3; writeregM = 3; regwriteM = 1; divE = 1;
        #12;
        chk("reset_fwdaE", {6'd0, forwardaE}, 8'd0);
        chk("reset_ctl", ctl(), 8'h00);

        step();
        rst_n = 1'b1;
        clear_inputs();
        #1;
        chk("idle_ctl", ctl(), 8'h00);

        // forwarding
        rsE = 3; writeregM = 3; regwriteM = 1; writeregW = 3; regwriteW = 1;
        rtE = 3; rsD = 3;
        #1;
        chk("fwdaE_M", {6'd0, forwardaE}, 8'd2);
        chk("fwdbE_M", {6'd0, forwardbE}, 8'd2);
        chk("fwdaD_M", {7'd0, forwardaD}, 8'd1);
        regwriteM = 0;
        #1;
        chk("fwdaE_W", {6'd0, forwardaE}, 8'd1);
        chk("fwdaD_off", {7'd0, forwardaD}, 8'd0);
        rsE = 0;
        #1;
        chk("fwdaE_r0", {6'd0, forwardaE}, 8'd0);
        chk("fwdbE_W", {6'd0, forwardbE}, 8'd1);

        // load-use
        step(); clear_inputs();
        memtoregE = 1; rtE = 5; rsD = 5;
        #1;
        chk("lu_stall", ctl(), 8'b1100_1000);
        rtE = 0;
        #1;
        chk("lu_r0", ctl(), 8'h00);

        // branch interlocks
        step(); clear_inputs();
        branchD = 1; regwriteE = 1; writeregE = 7; rtD = 7;
        #1;
        chk("br_stall_E", ctl(), 8'b1100_1000);
        step();
        regwriteE = 0; memtoregM = 1; writeregM = 7; regwriteM = 1;
        #1;
        chk("br_stall_M", ctl(), 8'b1100_1000);
        step();
        memtoregM = 0;
        #1;
        chk("br_fwd_ctl", ctl(), 8'h00);
        chk("br_fwdbD", {7'd0, forwardbD}, 8'd1);

        // divide, 4 cycles, with a load-use hazard masked during the hold
        step(); clear_inputs();
        divE = 1;
        #1;
        chk("div_c0", ctl(), 8'b1110_0110);
        step();
        memtoregE = 1; rtE = 5; rsD = 5;
        #1;
        chk("div_c1_masked", ctl(), 8'b1110_0101);
        step();
        memtoregE = 0;
        #1;
        chk("div_c2", ctl(), 8'b1110_0101);
        step(); #1;
        chk("div_c3", ctl(), 8'b1110_0101);
        step(); #1;
        chk("div_done", ctl(), 8'b0000_0001);
        step(); divE = 0; #1;
        chk("div_idle", ctl(), 8'h00);

        // multiply, single cycle latency
        step(); mulE = 1; #1;
        chk("mul_c0", ctl(), 8'b1110_0110);
        step(); #1;
        chk("mul_done", ctl(), 8'b0000_0001);
        step(); mulE = 0; #1;
        chk("mul_idle", ctl(), 8'h00);

        // exception in the second busy cycle, then a full restart
        step(); divE = 1; #1;
        chk("exc_start", ctl(), 8'b1110_0110);
        step(); #1;
        chk("exc_busy1", ctl(), 8'b1110_0101);
        step(); flush_excM = 1; #1;
        chk("exc_flush", ctl(), 8'b0001_1101);
        step(); flush_excM = 0; #1;
        chk("exc_restart", ctl(), 8'b1110_0110);
        for (int i = 1; i < 4; i++) begin
            step(); #1;
            chk($sformatf("exc_rbusy%0d", i), ctl(), 8'b1110_0101);
        end
        step(); #1;
        chk("exc_rdone", ctl(), 8'b0000_0001);
        step(); divE = 0; #1;
        chk("exc_ridle", ctl(), 8'h00);

        // asynchronous reset in the middle of a busy divide
        step(); divE = 1; #1;
        chk("rst_start", ctl(), 8'b1110_0110);
        step(); #2;
        chk("rst_busy", ctl(), 8'b1110_0101);
        rst_n = 1'b0;
        #1;
        chk("rst_async", ctl(), 8'h00);
        step(); rst_n = 1'b1; divE = 0; #1;
        chk("rst_release", ctl(), 8'h00);
        step(); #1;
        chk("rst_idle", ctl(), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Pipeline hazard controller for the 5-stage MIPS core, extending forwarding and load-use/branch interlock with multi-cycle multiply/divide support.
- Generalised register-address width and independent mul/div latencies.
- Internal FSM and counter that hold F/D/E and insert bubbles into M while the multi-cycle unit runs; exception flush from M overrides everything.
- Sits beside the datapath, combinational except for the md FSM.

Parameters:
REG_AW, 5, register-address width
MUL_LAT, 2, cycles a multiply occupies E (>=1)
DIV_LAT, 32, cycles a divide occupies E (>=1)
CNT_W, 6, counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
rsD, rtD, rsE, rtE  in  REG_AW  source regs in D/E
writeregE, writeregM, writeregW  in  REG_AW  destination regs
regwriteE, regwriteM, regwriteW  in  1  writeback enables
memtoregE, memtoregM  in  1  load in E/M
branchD  in  1  branch/compare in D
mulE, divE  in  1  multiply/divide op valid in E
flush_excM  in  1  exception/eret committed in M
forwardaD, forwardbD  out  1  M->D forward for branch compare
forwardaE, forwardbE  out  2  00 reg file, 01 from W, 10 from M
stallF, stallD, stallE  out  1  hold stage registers
flushD, flushE, flushM  out  1  clear stage registers to bubble
md_start  out  1  one-cycle start pulse to mul/div unit
md_busy  out  1  FSM not IDLE

Behaviour:
- Reset (rst_n=0, async): state IDLE, cnt 0; all outputs 0 while held in reset.
- Forwarding (combinational):
  - forwardaD = rsD!=0 & rsD==writeregM & regwriteM; forwardbD likewise with rtD.
  - forwardaE = 10 if rsE!=0 & rsE==writeregM & regwriteM; else 01 if rsE!=0 & rsE==writeregW & regwriteW; else 00. M has priority over W. forwardbE likewise with rtE.
- lu_stall = memtoregE & rtE!=0 & (rtE==rsD | rtE==rtD).
- br_stall = branchD & ((regwriteE & writeregE!=0 & (writeregE==rsD | writeregE==rtD)) | (memtoregM & writeregM!=0 & (writeregM==rsD | writeregM==rtD))).
- ld_stall = lu_stall | br_stall. When set: stallF=stallD=1, flushE=1.
- md FSM, states IDLE, BUSY, DONE:
  - IDLE & (mulE|divE) & !flush_excM: md_start=1; cnt<=LAT-1, where LAT=DIV_LAT if divE else MUL_LAT (divE wins if both set). Next state BUSY if LAT>1, else DONE. stallF/D/E=1 and flushM=1 this cycle.
  - BUSY: cnt<=cnt-1; stallF/D/E=1, flushM=1; when cnt==1, next state DONE.
  - DONE: no md stall; the E instruction advances with its result; next state IDLE unconditionally. mulE/divE is ignored in DONE (same instruction).
  - Total: op entering E at cycle t stalls cycles t..t+LAT-1 and advances at t+LAT. md_busy=1 in BUSY and DONE.
- Priority, highest first:
  1. flush_excM: flushD=flushE=flushM=1, all stalls 0, md_start 0, FSM->IDLE, cnt->0. Aborts any md op mid-flight.
  2. md stall: ld_stall is masked (flushE=0, so the E op is retained); stallF/D/E=1, flushM=1.
  3. ld_stall.
- flushD is asserted only by flush_excM.
- md_start never asserts twice for one instruction. Reset mid-op returns to IDLE immediately.

Decomposition:
- Shared package hazard_pkg: md state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and forward-select constants (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10).
- One sub-module: md_stall_fsm, holding the state register, counter, md_start and md stall.
- Forwarding and load/branch interlock stay combinational in the top.

Test Plan:
1. Forwarding: rsE=3, writeregM=3, regwriteM=1, writeregW=3, regwriteW=1 -> forwardaE=10. Clear regwriteM -> 01. Set rsE=0 -> 00.
2. Load-use: memtoregE=1, rtE=5, rsD=5 -> stallF=stallD=flushE=1 for exactly that cycle. Change rtE to 0 -> no stall.
3. Branch: branchD=1, regwriteE=1, writeregE=7, rtD=7 -> stall. Next cycle memtoregM=1, writeregM=7 -> stall again. Then forwardbD=1 with regwriteM -> no stall.
4. Divide, DIV_LAT=4: divE=1 held -> md_start pulses 1 cycle; stallE=flushM=1 for 4 cycles; DONE on the 5th; no second md_start. MUL_LAT=1 -> exactly 1 stall cycle.
5. Exception mid-divide: assert flush_excM at cycle 2 of BUSY -> flushD/E/M=1, stalls 0, md_busy=0 next cycle. A new divE afterwards restarts the full count.
6. rst_n low mid-BUSY (async, between edges) -> outputs/state cleared immediately. After release with mulE=0/divE=0 -> all stalls 0.
